// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, SRAM base address and cache address field positions
package cache_pkg;
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_WAIT} state_t;
  localparam logic [31:0] ADDR_BASE = 32'd1024;
  localparam int CACHE_ADDR_W = 17;
  localparam int LINE_W = 64;
  localparam int TAG_MSB = 16;
  localparam int TAG_LSB = 7;
  localparam int IDX_MSB = 6;
  localparam int IDX_LSB = 1;
  localparam int OFS_BIT = 0;
endpackage

// File: rtl/cache_addr_map.sv
// cache_addr_map: byte address to cache word address, (address - ADDR_BASE)[18:2]
module cache_addr_map
  import cache_pkg::*;
(
  input  logic [31:0]             address,
  output logic [CACHE_ADDR_W-1:0] cache_address
);
  assign cache_address = CACHE_ADDR_W'((address - ADDR_BASE) >> 2);
endmodule

// File: rtl/cache_controller.sv
// cache_controller: write-through no-write-allocate cache requester with read-miss fill from SRAM
module cache_controller
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    MEM_R_EN,
  input  logic                    MEM_W_EN,
  input  logic [31:0]             address,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic [31:0]             sram_address,
  output logic [31:0]             sram_wdata,
  output logic                    sram_read,
  output logic                    sram_write,
  input  logic                    sram_ready,
  input  logic [LINE_W-1:0]       sram_rdata,
  output logic                    Cache_WE,
  output logic                    Cache_RE,
  output logic                    checkInvalidation,
  output logic [CACHE_ADDR_W-1:0] CacheAddress,
  output logic [LINE_W-1:0]       CacheWriteData,
  input  logic                    hit,
  input  logic [31:0]             cache_rdata
);
  state_t state, state_n;
  logic [31:0] addr_q, data_q;
  logic idle, wr_req, rd_hit, rd_miss, fill;
  assign idle = state == IDLE;
  assign wr_req = idle && MEM_W_EN;
  assign rd_hit = idle && !MEM_W_EN && MEM_R_EN && hit;
  assign rd_miss = idle && !MEM_W_EN && MEM_R_EN && !hit;
  assign fill = state == RD_MISS && sram_ready;
  cache_addr_map u_map (
    .address       (idle ? address : addr_q),
    .cache_address (CacheAddress)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      if (wr_req || rd_miss) addr_q <= address;
      if (wr_req) data_q <= wdata;
    end
  end
  always_comb begin
    state_n = state;
    if (idle) state_n = wr_req ? WR_WAIT : rd_miss ? RD_MISS : IDLE;
    else if (sram_ready) state_n = IDLE;
  end
  always_comb begin
    sram_address = addr_q;
    sram_wdata = data_q;
    sram_read = state == RD_MISS;
    sram_write = state == WR_WAIT;
    Cache_WE = fill;
    Cache_RE = rd_hit;
    checkInvalidation = wr_req;
    CacheWriteData = sram_rdata;
    ready = idle ? !(wr_req || rd_miss) : sram_ready;
    rdata = rd_hit ? cache_rdata :
            fill ? (CacheAddress[OFS_BIT] ? sram_rdata[63:32] : sram_rdata[31:0]) : 32'd0;
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed self-checking bench for cache_controller
module tb_cache_controller;
  logic clk = 0, rst = 1;
  logic MEM_R_EN = 0, MEM_W_EN = 0, sram_ready = 0, hit = 0;
  logic [31:0] address = 0, wdata = 0, cache_rdata = 0;
  logic [63:0] sram_rdata = 0;
  logic [31:0] rdata, sram_address, sram_wdata;
  logic ready, sram_read, sram_write, Cache_WE, Cache_RE, checkInvalidation;
  logic [16:0] CacheAddress;
  logic [63:0] CacheWriteData;
  int errors = 0, checks = 0;
  cache_controller dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_ready(sram_ready), .sram_rdata(sram_rdata),
    .Cache_WE(Cache_WE), .Cache_RE(Cache_RE),
    .checkInvalidation(checkInvalidation), .CacheAddress(CacheAddress),
    .CacheWriteData(CacheWriteData), .hit(hit), .cache_rdata(cache_rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    cyc();
    cyc();
    rst = 0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_sram_read", sram_read, 0);
    check("rst_sram_write", sram_write, 0);
    check("rst_we", Cache_WE, 0);
    check("rst_re", Cache_RE, 0);
    check("rst_inv", checkInvalidation, 0);
    check("rst_rdata", rdata, 0);
    MEM_R_EN = 1; address = 1032; hit = 0;
    #1;
    check("miss_ready", ready, 0);
    check("miss_caddr", CacheAddress, 2);
    cyc();
    check("miss_sram_read", sram_read, 1);
    check("miss_sram_addr", sram_address, 1032);
    check("miss_wait_ready", ready, 0);
    repeat (4) cyc();
    check("miss_held", sram_read, 1);
    sram_ready = 1; sram_rdata = 64'hBBBB_0002_AAAA_0001;
    #1;
    check("fill_we", Cache_WE, 1);
    check("fill_caddr", CacheAddress, 2);
    check("fill_rdata", rdata, 32'hAAAA_0001);
    check("fill_ready", ready, 1);
    check("fill_line", CacheWriteData, 64'hBBBB_0002_AAAA_0001);
    cyc();
    sram_ready = 0; hit = 1; cache_rdata = 32'hAAAA_0001;
    #1;
    check("hit_re", Cache_RE, 1);
    check("hit_ready", ready, 1);
    check("hit_rdata", rdata, 32'hAAAA_0001);
    check("hit_no_read", sram_read, 0);
    cyc();
    MEM_R_EN = 0; hit = 0;
    #1;
    check("hit_re_pulse", Cache_RE, 0);
    check("idle_rdata", rdata, 0);
    cyc();
    MEM_R_EN = 1; address = 1036;
    #1;
    check("odd_caddr_live", CacheAddress, 3);
    cyc();
    MEM_R_EN = 0; address = 0;
    cyc();
    sram_ready = 1;
    #1;
    check("odd_caddr_latched", CacheAddress, 3);
    check("odd_rdata", rdata, 32'hBBBB_0002);
    check("odd_we", Cache_WE, 1);
    cyc();
    sram_ready = 0;
    #1;
    check("odd_done_read", sram_read, 0);
    check("odd_done_we", Cache_WE, 0);
    MEM_W_EN = 1; address = 1032; wdata = 32'h1234_5678;
    #1;
    check("wr_inv", checkInvalidation, 1);
    check("wr_ready", ready, 0);
    check("wr_we0", Cache_WE, 0);
    cyc();
    MEM_W_EN = 0; address = 0; wdata = 0;
    #1;
    check("wr_inv_pulse", checkInvalidation, 0);
    for (int i = 0; i < 3; i++) begin
      check("wr_strobe", sram_write, 1);
      check("wr_sram_wdata", sram_wdata, 32'h1234_5678);
      check("wr_sram_addr", sram_address, 1032);
      check("wr_no_we", Cache_WE, 0);
      check("wr_wait_ready", ready, 0);
      cyc();
    end
    sram_ready = 1;
    #1;
    check("wr_done_ready", ready, 1);
    check("wr_done_we", Cache_WE, 0);
    check("wr_done_strobe", sram_write, 1);
    cyc();
    sram_ready = 0;
    #1;
    check("wr_idle_strobe", sram_write, 0);
    MEM_R_EN = 1; MEM_W_EN = 1; address = 1040; wdata = 32'hCAFE_F00D; hit = 1;
    #1;
    check("pri_inv", checkInvalidation, 1);
    check("pri_re", Cache_RE, 0);
    check("pri_ready", ready, 0);
    cyc();
    MEM_R_EN = 0; MEM_W_EN = 0; hit = 0;
    #1;
    check("pri_write", sram_write, 1);
    check("pri_read", sram_read, 0);
    check("pri_wdata", sram_wdata, 32'hCAFE_F00D);
    sram_ready = 1;
    cyc();
    sram_ready = 0;
    #1;
    check("ign_ready", ready, 1);
    sram_ready = 1;
    #1;
    check("ign_we", Cache_WE, 0);
    check("ign_ready_pulse", ready, 1);
    cyc();
    sram_ready = 0;
    #1;
    check("ign_state", sram_read | sram_write, 0);
    MEM_R_EN = 1; address = 1048; hit = 0;
    cyc();
    MEM_R_EN = 0;
    #1;
    check("abort_pre", sram_read, 1);
    rst = 1;
    cyc();
    rst = 0;
    #1;
    check("abort_read", sram_read, 0);
    check("abort_ready", ready, 1);
    check("abort_addr", sram_address, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
